// File: rtl/seven_seg_mux_if.sv
// Segment-pattern inputs and display-pin outputs of the seven-segment scanner.
// The master supplies the four digit patterns; the slave (the scanner) drives the pins.
interface seven_seg_mux_if;
  logic [6:0] c1;
  logic [6:0] c2;
  logic [6:0] c3;
  logic [6:0] c4;
  logic [3:0] AN;
  logic [6:0] cathode;

  modport master (
    output c1, c2, c3, c4,
    input  AN, cathode
  );

  modport slave (
    input  c1, c2, c3, c4,
    output AN, cathode
  );
endinterface

// File: rtl/seven_seg_mux.sv
// Time-multiplexed 4-digit common-anode seven-segment driver.
// One active-low anode at a time; anode and cathode registered on the same edge.
module seven_seg_mux #(
  parameter int TICK_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset,
  seven_seg_mux_if.slave    bus
);

  localparam int             CW      = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_reg;
  logic [1:0]    idx_reg;
  logic [3:0]    an_reg;
  logic [6:0]    cathode_reg;

  logic [6:0]    pattern [4];
  logic [3:0]    an_sel  [4];

  assign pattern[0] = bus.c1;
  assign pattern[1] = bus.c2;
  assign pattern[2] = bus.c3;
  assign pattern[3] = bus.c4;

  // Index 0 is the leftmost digit, which sits on AN[3].
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_anode
      assign an_sel[gi] = ~(4'b1000 >> gi);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg     <= '0;
      idx_reg     <= 2'd0;
      an_reg      <= 4'b1111;
      cathode_reg <= 7'b1111111;
    end else begin
      an_reg      <= an_sel[idx_reg];
      cathode_reg <= pattern[idx_reg];
      if (cnt_reg == CNT_MAX) begin
        cnt_reg <= '0;
        idx_reg <= idx_reg + 2'd1;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign bus.AN      = an_reg;
  assign bus.cathode = cathode_reg;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Randomized self-checking bench for seven_seg_mux (TICK_CYCLES=4 and TICK_CYCLES=1).
// Expected outputs come from an edge-count model: digit = (edges since release / T) mod 4.
module tb_seven_seg_mux;

  logic clk = 1'b0;
  logic rst4 = 1'b1;
  logic rst1 = 1'b1;

  seven_seg_mux_if bus4 ();
  seven_seg_mux_if bus1 ();

  seven_seg_mux #(.TICK_CYCLES(4)) dut4 (.clk(clk), .reset(rst4), .bus(bus4.slave));
  seven_seg_mux #(.TICK_CYCLES(1)) dut1 (.clk(clk), .reset(rst1), .bus(bus1.slave));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int k4 = 0;
  int k1 = 0;
  logic [3:0] exp_an4, exp_an1;
  logic [6:0] exp_cat4, exp_cat1;

  function automatic logic [10:0] ref_out(input int k, input int t,
                                          input logic [6:0] a, b, c, d);
    int dig;
    logic [6:0] p;
    logic [3:0] an;
    dig = (k / t) % 4;
    case (dig)
      0:       p = a;
      1:       p = b;
      2:       p = c;
      default: p = d;
    endcase
    an = 4'b1111 ^ (4'b1000 >> dig);
    return {an, p};
  endfunction

  // Advance one clock; model consumes the inputs as they were just before the edge.
  task automatic clk_step();
    logic [6:0] a4, b4, c4, d4, a1, b1, c1, d1;
    logic pr4, pr1;
    a4 = bus4.c1; b4 = bus4.c2; c4 = bus4.c3; d4 = bus4.c4; pr4 = rst4;
    a1 = bus1.c1; b1 = bus1.c2; c1 = bus1.c3; d1 = bus1.c4; pr1 = rst1;
    @(posedge clk);
    #1;
    if (pr4) begin
      exp_an4 = 4'b1111; exp_cat4 = 7'b1111111; k4 = 0;
    end else begin
      {exp_an4, exp_cat4} = ref_out(k4, 4, a4, b4, c4, d4);
      k4++;
    end
    if (pr1) begin
      exp_an1 = 4'b1111; exp_cat1 = 7'b1111111; k1 = 0;
    end else begin
      {exp_an1, exp_cat1} = ref_out(k1, 1, a1, b1, c1, d1);
      k1++;
    end
  endtask

  task automatic randomize_inputs4();
    bus4.c1 = 7'($urandom); bus4.c2 = 7'($urandom);
    bus4.c3 = 7'($urandom); bus4.c4 = 7'($urandom);
  endtask

  task automatic randomize_inputs1();
    bus1.c1 = 7'($urandom); bus1.c2 = 7'($urandom);
    bus1.c3 = 7'($urandom); bus1.c4 = 7'($urandom);
  endtask

  task automatic test_reset();
    rst4 = 1'b1; rst1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      randomize_inputs4();
      randomize_inputs1();
      clk_step();
      n_cmp++;
      if (bus4.AN !== 4'b1111 || bus4.cathode !== 7'b1111111) begin
        n_err++;
        $display("FAIL reset4 edge%0d: AN=%b cathode=%b, required 1111/1111111", i, bus4.AN, bus4.cathode);
      end
      n_cmp++;
      if (bus1.AN !== 4'b1111 || bus1.cathode !== 7'b1111111) begin
        n_err++;
        $display("FAIL reset1 edge%0d: AN=%b cathode=%b, required 1111/1111111", i, bus1.AN, bus1.cathode);
      end
    end
  endtask

  task automatic test_basic_scan();
    logic [3:0] an_tbl [4];
    logic [6:0] cat_tbl [4];
    an_tbl  = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    cat_tbl = '{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
    bus4.c1 = cat_tbl[0]; bus4.c2 = cat_tbl[1];
    bus4.c3 = cat_tbl[2]; bus4.c4 = cat_tbl[3];
    rst4 = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      clk_step();
      n_cmp++;
      if (bus4.AN !== an_tbl[(e-1)/4] || bus4.cathode !== cat_tbl[(e-1)/4]) begin
        n_err++;
        $display("FAIL basic_scan edge%0d: AN=%b cathode=%b, required %b/%b",
                 e, bus4.AN, bus4.cathode, an_tbl[(e-1)/4], cat_tbl[(e-1)/4]);
      end
    end
  endtask

  task automatic test_wraparound();
    clk_step();
    n_cmp++;
    if (bus4.AN !== 4'b0111 || bus4.cathode !== 7'b1111001) begin
      n_err++;
      $display("FAIL wrap edge17: AN=%b cathode=%b, required 0111/1111001", bus4.AN, bus4.cathode);
    end
    for (int i = 0; i < 40; i++) begin
      randomize_inputs4();
      clk_step();
      n_cmp++;
      if (bus4.AN !== exp_an4 || bus4.cathode !== exp_cat4) begin
        n_err++;
        $display("FAIL wrap step%0d: AN=%b cathode=%b, required %b/%b",
                 i, bus4.AN, bus4.cathode, exp_an4, exp_cat4);
      end
      n_cmp++;
      if ($countones(~bus4.AN) != 1) begin
        n_err++;
        $display("FAIL one_anode step%0d: AN=%b, required exactly one low bit", i, bus4.AN);
      end
    end
  endtask

  task automatic test_live_update();
    rst4 = 1'b1;
    clk_step();
    rst4 = 1'b0;
    randomize_inputs4();
    bus4.c2 = 7'b1010101;
    for (int e = 1; e <= 5; e++) clk_step();
    bus4.c2 = 7'b0000000;
    clk_step();
    n_cmp++;
    if (bus4.AN !== 4'b1011 || bus4.cathode !== 7'b0000000) begin
      n_err++;
      $display("FAIL live_update: AN=%b cathode=%b, required 1011/0000000", bus4.AN, bus4.cathode);
    end
    n_cmp++;
    if (bus4.AN !== exp_an4 || bus4.cathode !== exp_cat4) begin
      n_err++;
      $display("FAIL live_update_model: AN=%b cathode=%b, required %b/%b",
               bus4.AN, bus4.cathode, exp_an4, exp_cat4);
    end
  endtask

  task automatic test_mid_scan_reset();
    rst4 = 1'b1;
    clk_step();
    rst4 = 1'b0;
    randomize_inputs4();
    for (int e = 1; e <= 10; e++) clk_step();
    n_cmp++;
    if (bus4.AN !== 4'b1101) begin
      n_err++;
      $display("FAIL mid_reset_pre: AN=%b, required 1101", bus4.AN);
    end
    rst4 = 1'b1;
    clk_step();
    n_cmp++;
    if (bus4.AN !== 4'b1111 || bus4.cathode !== 7'b1111111) begin
      n_err++;
      $display("FAIL mid_reset: AN=%b cathode=%b, required 1111/1111111", bus4.AN, bus4.cathode);
    end
    rst4 = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      clk_step();
      n_cmp++;
      if (bus4.AN !== (e <= 4 ? 4'b0111 : 4'b1011) || bus4.cathode !== (e <= 4 ? bus4.c1 : bus4.c2)) begin
        n_err++;
        $display("FAIL mid_reset_restart edge%0d: AN=%b cathode=%b, required %b/%b", e,
                 bus4.AN, bus4.cathode, (e <= 4 ? 4'b0111 : 4'b1011), (e <= 4 ? bus4.c1 : bus4.c2));
      end
    end
  endtask

  task automatic test_tick1();
    logic [3:0] an_tbl [4];
    an_tbl = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    randomize_inputs1();
    rst1 = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      clk_step();
      n_cmp++;
      if (bus1.AN !== an_tbl[(e-1)%4] || bus1.AN !== exp_an1 || bus1.cathode !== exp_cat1) begin
        n_err++;
        $display("FAIL tick1 edge%0d: AN=%b cathode=%b, required %b/%b",
                 e, bus1.AN, bus1.cathode, exp_an1, exp_cat1);
      end
      randomize_inputs1();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      randomize_inputs4();
      rst4 = ($urandom_range(0, 24) == 0);
      clk_step();
      n_cmp++;
      if (bus4.AN !== exp_an4 || bus4.cathode !== exp_cat4) begin
        n_err++;
        $display("FAIL random step%0d: AN=%b cathode=%b, required %b/%b",
                 i, bus4.AN, bus4.cathode, exp_an4, exp_cat4);
      end
    end
    rst4 = 1'b0;
  endtask

  initial begin
    bus4.c1 = '1; bus4.c2 = '1; bus4.c3 = '1; bus4.c4 = '1;
    bus1.c1 = '1; bus1.c2 = '1; bus1.c3 = '1; bus1.c4 = '1;
    @(posedge clk);
    #1;
    test_reset();
    test_basic_scan();
    test_wraparound();
    test_live_update();
    test_mid_scan_reset();
    test_tick1();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
